// File: rtl/mem_ctrl.sv
// mem_ctrl: DEPTH x WIDTH register-array memory behind a one-request-at-a-time
// controller. An accepted request completes after LATENCY extra cycles and is
// signalled by a single-cycle mem_ready pulse. A combined read+write returns
// the pre-write contents.
module mem_ctrl #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 32,
  parameter  int LATENCY = 0,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic             read_enable,
  input  logic [AW-1:0]    write_addr,
  input  logic [AW-1:0]    read_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             mem_ready,
  output logic [WIDTH-1:0] read_data
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Request snapshot taken at acceptance; later input changes cannot alter it.
  typedef struct packed {
    logic             we;
    logic             re;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] read_data_q, read_data_d;
  logic             mem_ready_q, mem_ready_d;

  // Access performed at the coming edge, and which request it serves.
  req_t             acc;
  logic             acc_go;

  // Addresses at or beyond DEPTH only exist when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  // Control: accept in IDLE, count down in WAIT, fire the access on the last count.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    acc     = req_q;
    acc_go  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (write_enable || read_enable) begin
          req_d = '{we: write_enable, re: read_enable, waddr: write_addr,
                    raddr: read_addr, wdata: write_data};
          if (LATENCY == 0) begin
            acc    = req_d;
            acc_go = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 8'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        // Requests arriving here are dropped, not queued.
        if (cnt_q == 8'd1) begin
          acc_go  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: read sees mem_q (pre-write), write lands in mem_d at the same edge.
  always_comb begin
    mem_d       = mem_q;
    read_data_d = read_data_q;
    mem_ready_d = acc_go;
    if (acc_go && acc.we && in_range(acc.waddr)) begin
      mem_d[acc.waddr] = acc.wdata;
    end
    if (acc_go && acc.re) begin
      read_data_d = in_range(acc.raddr) ? mem_q[acc.raddr] : '0;
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      // NOTE: the array is deliberately reset; reads after reset must return 0.
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      mem_q       <= mem_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl. Four instances: LATENCY=0 (DEPTH 16
// and DEPTH 12 sharing one stimulus), LATENCY=3 and LATENCY=4. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // LATENCY=0 stimulus (drives dut0 and dut_np)
  logic        a_rst, a_we, a_re;
  logic [3:0]  a_waddr, a_raddr;
  logic [31:0] a_wdata;
  logic        a_ready, np_ready;
  logic [31:0] a_data, np_data;

  // LATENCY=3 stimulus
  logic        b_rst, b_we, b_re;
  logic [3:0]  b_waddr, b_raddr;
  logic [31:0] b_wdata;
  logic        b_ready;
  logic [31:0] b_data;

  // LATENCY=4 stimulus
  logic        c_rst, c_we, c_re;
  logic [3:0]  c_waddr, c_raddr;
  logic [31:0] c_wdata;
  logic        c_ready;
  logic [31:0] c_data;

  mem_ctrl #(.DEPTH(16), .WIDTH(32), .LATENCY(0)) dut0 (
    .clk(clk), .rst(a_rst), .write_enable(a_we), .read_enable(a_re),
    .write_addr(a_waddr), .read_addr(a_raddr), .write_data(a_wdata),
    .mem_ready(a_ready), .read_data(a_data));

  mem_ctrl #(.DEPTH(12), .WIDTH(32), .LATENCY(0)) dut_np (
    .clk(clk), .rst(a_rst), .write_enable(a_we), .read_enable(a_re),
    .write_addr(a_waddr), .read_addr(a_raddr), .write_data(a_wdata),
    .mem_ready(np_ready), .read_data(np_data));

  mem_ctrl #(.DEPTH(16), .WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(b_rst), .write_enable(b_we), .read_enable(b_re),
    .write_addr(b_waddr), .read_addr(b_raddr), .write_data(b_wdata),
    .mem_ready(b_ready), .read_data(b_data));

  mem_ctrl #(.DEPTH(16), .WIDTH(32), .LATENCY(4)) dut4 (
    .clk(clk), .rst(c_rst), .write_enable(c_we), .read_enable(c_re),
    .write_addr(c_waddr), .read_addr(c_raddr), .write_data(c_wdata),
    .mem_ready(c_ready), .read_data(c_data));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_waddr = '0; a_raddr = '0; a_wdata = '0;
    b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_waddr = '0; b_raddr = '0; b_wdata = '0;
    c_rst = 1'b1; c_we = 1'b0; c_re = 1'b0; c_waddr = '0; c_raddr = '0; c_wdata = '0;
    repeat (3) tick();
    check("reset_ready_l0", 32'(a_ready), 32'd0);
    check("reset_data_l0",  a_data, 32'd0);
    check("reset_ready_l3", 32'(b_ready), 32'd0);
    check("reset_ready_l4", 32'(c_ready), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();
    check("idle_ready_l0", 32'(a_ready), 32'd0);

    // ---- Post-reset sweep, one read per cycle, LATENCY=0 ----
    a_re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_raddr = 4'(i);
      tick();
      check($sformatf("sweep_ready[%0d]", i), 32'(a_ready), 32'd1);
      check($sformatf("sweep_data[%0d]", i),  a_data, 32'd0);
    end
    a_re = 1'b0;
    tick();
    check("sweep_ready_drop", 32'(a_ready), 32'd0);

    // ---- Writes, LATENCY=0 ----
    a_we = 1'b1;
    a_waddr = 4'd3;  a_wdata = 32'hDEADBEEF; tick();
    check("wr3_ready", 32'(a_ready), 32'd1);
    a_waddr = 4'd15; a_wdata = 32'h12345678; tick();
    check("wr15_ready", 32'(a_ready), 32'd1);
    a_waddr = 4'd0;  a_wdata = 32'hFFFFFFFF; tick();
    check("wr0_ready", 32'(a_ready), 32'd1);
    check("wr_data_unchanged", a_data, 32'd0);
    a_we = 1'b0;
    tick();
    check("wr_ready_drop", 32'(a_ready), 32'd0);

    // ---- Read-back ----
    a_re = 1'b1;
    a_raddr = 4'd3;  tick();
    check("rd3", a_data, 32'hDEADBEEF);
    check("np_rd3", np_data, 32'hDEADBEEF);
    a_raddr = 4'd15; tick();
    check("rd15", a_data, 32'h12345678);
    check("np_rd15_oob", np_data, 32'd0);
    check("np_rd15_ready", 32'(np_ready), 32'd1);
    a_raddr = 4'd0;  tick();
    check("rd0", a_data, 32'hFFFFFFFF);
    check("np_rd0", np_data, 32'hFFFFFFFF);
    a_raddr = 4'd13; tick();
    check("rd13", a_data, 32'd0);
    check("np_rd13_oob", np_data, 32'd0);
    check("np_rd13_ready", 32'(np_ready), 32'd1);
    for (int i = 1; i < 15; i++) begin
      if (i != 3) begin
        a_raddr = 4'(i);
        tick();
        check($sformatf("rd_other[%0d]", i), a_data, 32'd0);
      end
    end
    a_re = 1'b0;
    tick();

    // ---- Same-address read+write ----
    a_we = 1'b1; a_waddr = 4'd5; a_wdata = 32'hA5A5A5A5; tick();
    check("pre5_ready", 32'(a_ready), 32'd1);
    a_re = 1'b1; a_raddr = 4'd5; a_wdata = 32'h5A5A5A5A; tick();
    check("rw5_ready", 32'(a_ready), 32'd1);
    check("rw5_old_data", a_data, 32'hA5A5A5A5);
    a_we = 1'b0; a_re = 1'b0; tick();
    check("rw5_single_pulse", 32'(a_ready), 32'd0);
    a_re = 1'b1; tick();
    check("rd5_new", a_data, 32'h5A5A5A5A);
    a_re = 1'b0;

    // ---- Write-only completion keeps read_data ----
    a_we = 1'b1; a_waddr = 4'd2; a_wdata = 32'hCAFE0002; tick();
    a_we = 1'b0; a_re = 1'b1; a_raddr = 4'd2; tick();
    check("rd2", a_data, 32'hCAFE0002);
    a_re = 1'b0; a_we = 1'b1; a_waddr = 4'd4; a_wdata = 32'h9; tick();
    check("wo_ready", 32'(a_ready), 32'd1);
    check("wo_data_held", a_data, 32'hCAFE0002);
    a_we = 1'b0; a_re = 1'b1; a_raddr = 4'd4; tick();
    check("rd4", a_data, 32'h9);
    a_re = 1'b0; tick();
    check("rd4_held", a_data, 32'h9);

    // ---- LATENCY=3: write 0x33 to 1 accepted at edge k ----
    b_we = 1'b1; b_waddr = 4'd1; b_wdata = 32'h33;
    for (int j = 1; j <= 5; j++) begin
      tick();
      b_we = 1'b0;
      check($sformatf("l3_wr_ready[%0d]", j), 32'(b_ready), (j == 4) ? 32'd1 : 32'd0);
    end
    // Read 1 accepted at k; read_enable held with a different address during
    // k+1..k+3 is ignored; held re at k+4 is the next acceptance (address 2).
    b_re = 1'b1; b_raddr = 4'd1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) b_raddr = 4'd2;
      if (j == 5) b_re = 1'b0;
      check($sformatf("l3_rd_ready[%0d]", j), 32'(b_ready),
            (j == 4 || j == 8) ? 32'd1 : 32'd0);
      if (j == 4) check("l3_rd1_data", b_data, 32'h33);
      if (j == 8) check("l3_rd2_data", b_data, 32'd0);
    end

    // ---- LATENCY=4: load read_data with a nonzero value first ----
    c_we = 1'b1; c_waddr = 4'd6; c_wdata = 32'hABCD;
    for (int j = 1; j <= 6; j++) begin
      tick();
      c_we = 1'b0;
      check($sformatf("l4_wr_ready[%0d]", j), 32'(c_ready), (j == 5) ? 32'd1 : 32'd0);
    end
    c_re = 1'b1; c_raddr = 4'd6;
    for (int j = 1; j <= 5; j++) begin
      tick();
      c_re = 1'b0;
      if (j == 5) check("l4_rd6_data", c_data, 32'hABCD);
    end
    tick();
    // Write 0x1111 to 7 at edge k, reset at edge k+2.
    c_we = 1'b1; c_waddr = 4'd7; c_wdata = 32'h1111;
    tick();                 // after k
    c_we = 1'b0;
    tick();                 // after k+1
    c_rst = 1'b1;
    tick();                 // after k+2 (reset edge)
    c_rst = 1'b0;
    check("l4_rst_data", c_data, 32'd0);
    check("l4_rst_ready", 32'(c_ready), 32'd0);
    for (int j = 3; j <= 7; j++) begin
      tick();
      check($sformatf("l4_abort_ready[%0d]", j), 32'(c_ready), 32'd0);
    end
    c_re = 1'b1; c_raddr = 4'd7;
    for (int j = 1; j <= 5; j++) begin
      tick();
      c_re = 1'b0;
      check($sformatf("l4_rd7_ready[%0d]", j), 32'(c_ready), (j == 5) ? 32'd1 : 32'd0);
      if (j == 5) check("l4_rd7_data", c_data, 32'd0);
    end
    c_re = 1'b1; c_raddr = 4'd6;
    for (int j = 1; j <= 5; j++) begin
      tick();
      c_re = 1'b0;
      if (j == 5) check("l4_rd6_cleared", c_data, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port-style memory controller wrapping a DEPTH x WIDTH register array.
- Accepts one read and/or write request at a time and completes it after a programmable LATENCY.
- Signals completion with a one-cycle mem_ready pulse.
- Used as the backing store / memory model behind queue and stack logic in the in-order single-issue core.

Parameters:
- DEPTH, 16, number of words; address width AW = $clog2(DEPTH), minimum 1.
- WIDTH, 32, data word width in bits.
- LATENCY, 0, extra wait cycles between request acceptance and the memory access/completion. Range 0..255.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- write_enable  input  1  write request.
- read_enable  input  1  read request.
- write_addr  input  AW  write word address.
- read_addr  input  AW  read word address.
- write_data  input  WIDTH  write data.
- mem_ready  output  1  one-cycle completion pulse for the accepted request.
- read_data  output  WIDTH  registered read result; valid while mem_ready is high, held afterwards.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All DEPTH words cleared to 0.
  - read_data=0, mem_ready=0.
  - Latency counter cleared; state=IDLE.
  - Reset mid-operation aborts the pending request, with no write performed and no mem_ready pulse.
- States:
  - IDLE: able to accept a request.
  - WAIT: counting LATENCY cycles.
- Acceptance:
  - At edge k, in IDLE, with write_enable|read_enable=1, the request is accepted.
  - Both enables, both addresses and write_data are captured at acceptance; later input changes have no effect on that request.
- LATENCY=0:
  - The access is performed at edge k: write stored and/or read_data loaded.
  - mem_ready=1 for the cycle after edge k.
  - The controller stays IDLE and may accept a new request at edge k+1.
  - Requests held high continuously give one completion per cycle.
- LATENCY=N>0:
  - Go to WAIT with counter=N.
  - Counter decrements each edge; requests presented during WAIT are ignored, not queued.
  - The access is performed at edge k+N, with mem_ready=1 for the following cycle.
  - Return to IDLE, ready to accept at edge k+N+1.
- mem_ready rules:
  - Exactly one cycle high per accepted request; otherwise 0.
  - Write-only requests also pulse mem_ready; read_data is unchanged.
- Simultaneous read+write in one request:
  - Single completion, both operations done at the same edge.
  - The read returns the pre-write contents, including when the addresses are equal.
- read_data holds its last read value until the next read completes.
- Out-of-range address (non-power-of-2 DEPTH, addr >= DEPTH): write ignored; read returns 0; mem_ready still pulses.
- No other side effects: no error outputs, no byte enables.

Test Plan:
- Post-reset sweep, LATENCY=0: rst high 3 cycles then low; read_enable=1, read_addr 0..15, one per cycle -> mem_ready each following cycle, read_data=0x00000000 for all 16.
- Write/read-back, LATENCY=0:
  - Write 0xDEADBEEF@3, 0x12345678@15, 0xFFFFFFFF@0 -> three mem_ready pulses.
  - Then read 3, 15, 0 -> same values in that order.
  - All other addresses still read 0.
- LATENCY=3:
  - Read accepted at edge k -> mem_ready only in the cycle after edge k+3.
  - A new read_enable asserted during cycles k+1..k+3 is ignored, producing no extra pulse.
  - Next acceptance occurs at edge k+4.
- Same-address read+write: mem[5]=0xA5A5A5A5; request write 0x5A5A5A5A@5 with read@5 -> read_data=0xA5A5A5A5 with a single pulse; subsequent read of 5 returns 0x5A5A5A5A.
- Reset mid-operation, LATENCY=4:
  - Write 0x1111 to 7, assert rst at edge k+2 -> no mem_ready; mem[7] reads 0 after reset.
  - read_data=0 immediately after reset.
- Write-only completion: read 2 returns 0xCAFE0002, then write 0x9 to 4 -> mem_ready pulses with read_data remaining 0xCAFE0002.
